regfile_scoreboard: RTL

- Parametrised successor to the decode-stage GPR file plus HI/LO pair: N read ports, M write ports, optional same-cycle write-to-read bypass.
- Adds a per-register pending-write scoreboard so decode can detect RAW hazards and stall, instead of relying only on the forwarder.
- Sits in the decode stage; writeback drives write ports, decode drives read and claim ports.

---
 rtl/regfile_scoreboard_if.sv | 36 +++
 rtl/regfile_scoreboard.sv | 134 +++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bus of the register file: read ports, write ports, claim port, HI/LO.
interface regfile_scoreboard_if #(
  parameter int unsigned READ_PORTS  = 2,
  parameter int unsigned WRITE_PORTS = 1,
  parameter int unsigned ADDR        = 5,
  parameter int unsigned WIDTH       = 32
);
  logic [READ_PORTS*ADDR-1:0]   raddr;
  logic [READ_PORTS*WIDTH-1:0]  rdata;
  logic [READ_PORTS-1:0]        rbusy;
  logic [WRITE_PORTS-1:0]       we;
  logic [WRITE_PORTS*ADDR-1:0]  waddr;
  logic [WRITE_PORTS*WIDTH-1:0] wdata;
  logic                         claim_valid;
  logic [ADDR-1:0]              claim_addr;
  logic                         claim_ready;
  logic                         flush;
  logic                         we_hi;
  logic                         we_lo;
  logic [WIDTH-1:0]             din_hi;
  logic [WIDTH-1:0]             din_lo;
  logic [WIDTH-1:0]             hi;
  logic [WIDTH-1:0]             lo;

  modport master (
    output raddr, we, waddr, wdata, claim_valid, claim_addr, flush,
    output we_hi, we_lo, din_hi, din_lo,
    input  rdata, rbusy, claim_ready, hi, lo
  );

  modport slave (
    input  raddr, we, waddr, wdata, claim_valid, claim_addr, flush,
    input  we_hi, we_lo, din_hi, din_lo,
    output rdata, rbusy, claim_ready, hi, lo
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Decode-stage GPR file with HI/LO pair and a per-register pending-write scoreboard.
// Claims count outstanding writes per register; each write-port write retires one.
module regfile_scoreboard #(
  parameter int unsigned READ_PORTS  = 2,
  parameter int unsigned WRITE_PORTS = 1,
  parameter int unsigned ADDR        = 5,
  parameter int unsigned WIDTH       = 32,
  parameter bit          ZERO_REG    = 1'b1,
  parameter bit          BYPASS      = 1'b1,
  parameter int unsigned CNT_W       = 2
) (
  input logic                clk,
  input logic                rst_n,
  regfile_scoreboard_if.slave bus
);

  localparam int unsigned NREG = 2 ** ADDR;
  localparam int unsigned RW   = $clog2(WRITE_PORTS + 1);
  // Wide enough for cnt + claim without overflow before subtracting retires
  localparam int unsigned SW   = CNT_W + RW + 1;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [WIDTH-1:0] gpr_q [NREG];
  logic [WIDTH-1:0] gpr_d [NREG];
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [RW-1:0]    ret_cnt [NREG];
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             claim_zero, claim_ok;

  function automatic logic is_zero(input logic [ADDR-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Number of write ports retiring each register this cycle
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      ret_cnt[r] = '0;
      for (int unsigned j = 0; j < WRITE_PORTS; j++) begin
        if (bus.we[j] && (bus.waddr[j*ADDR +: ADDR] == ADDR'(r))) begin
          ret_cnt[r] = ret_cnt[r] + RW'(1);
        end
      end
    end
  end

  // Claim acceptance looks at the current count only, not same-cycle retires
  always_comb begin
    claim_zero      = is_zero(bus.claim_addr);
    bus.claim_ready = !bus.claim_valid || claim_zero || (cnt_q[bus.claim_addr] != CntMax);
    claim_ok        = bus.claim_valid && bus.claim_ready && !claim_zero;
  end

  // Counter next state: +claim -retires, floored at zero; flush wins over both
  always_comb begin
    logic [SW-1:0] sum;
    logic [SW-1:0] ret;
    sum = '0;
    ret = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      sum = SW'(cnt_q[r]) + SW'(claim_ok && (bus.claim_addr == ADDR'(r)));
      ret = SW'(ret_cnt[r]);
      if (bus.flush || (ZERO_REG && (r == 0))) begin
        cnt_d[r] = '0;
      end else if (sum > ret) begin
        cnt_d[r] = CNT_W'(sum - ret);
      end else begin
        cnt_d[r] = '0;
      end
    end
  end

  // GPR writes; later ports overwrite earlier ones so the highest index wins
  always_comb begin
    gpr_d = gpr_q;
    for (int unsigned j = 0; j < WRITE_PORTS; j++) begin
      if (bus.we[j] && !is_zero(bus.waddr[j*ADDR +: ADDR])) begin
        gpr_d[bus.waddr[j*ADDR +: ADDR]] = bus.wdata[j*WIDTH +: WIDTH];
      end
    end
  end

  // Combinational reads with optional same-cycle forwarding and hazard flag
  always_comb begin
    logic [ADDR-1:0] a;
    a         = '0;
    bus.rdata = '0;
    bus.rbusy = '0;
    for (int unsigned i = 0; i < READ_PORTS; i++) begin
      a = bus.raddr[i*ADDR +: ADDR];
      if (!is_zero(a)) begin
        bus.rdata[i*WIDTH +: WIDTH] = gpr_q[a];
        if (BYPASS) begin
          for (int unsigned j = 0; j < WRITE_PORTS; j++) begin
            if (bus.we[j] && (bus.waddr[j*ADDR +: ADDR] == a)) begin
              bus.rdata[i*WIDTH +: WIDTH] = bus.wdata[j*WIDTH +: WIDTH];
            end
          end
          // A retiring write this cycle is already covered by the bypass
          bus.rbusy[i] = SW'(cnt_q[a]) > SW'(ret_cnt[a]);
        end else begin
          bus.rbusy[i] = cnt_q[a] != '0;
        end
      end
    end
  end

  // HI/LO next state, independent enables
  always_comb begin
    hi_d = bus.we_hi ? bus.din_hi : hi_q;
    lo_d = bus.we_lo ? bus.din_lo : lo_q;
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        gpr_q[r] <= '0;
        cnt_q[r] <= '0;
      end
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      gpr_q <= gpr_d;
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule
